cache_miss_handler: RTL and testbench
=====================================

# cache_miss_handler

Write-back, write-allocate cache controller sitting between the processor-side request port and the RAM block of the two-level memory hierarchy. It holds a 2-line fully associative cache (8-bit tag = full address, 8-bit data, valid/dirty per line, single LRU pointer). It is the initiator toward RAM: it issues line fills on read misses and write-backs on dirty evictions over a req/ack handshake.

## Interface
- ADDR_W, 8, address width; the tag is the full address.
- DATA_W, 8, data word width; one word per line.

Ports (name, direction, width, meaning):
- clock  in  1  single clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- cpuReq  in  1  request strobe; sampled only while cpuReady=1.
- cpuWrite  in  1  1 = write, 0 = read; latched with cpuReq.
- cpuAddr  in  ADDR_W  request address; latched with cpuReq.
- cpuDataIn  in  DATA_W  write data; latched with cpuReq.
- cpuReady  out  1  high only in IDLE.
- cpuDone  out  1  one-cycle completion pulse.
- cpuDataOut  out  DATA_W  read data; valid while cpuDone=1 and held until the next completion.
- hit  out  1  1 = the completed access hit; valid while cpuDone=1 and held until the next completion.
- ramReq  out  1  RAM request; held until ramAck.
- ramWrite  out  1  1 = write-back, 0 = fill.
- ramAddr  out  ADDR_W  RAM address.
- ramDataOut  out  DATA_W  write-back data.
- ramAck  in  1  RAM completion; sampled on the rising edge.
- ramDataIn  in  DATA_W  fill data; valid in the cycle ramAck=1.
- hitCount  out  8  hit counter (see Configuration).
- missCount  out  8  miss counter (see Configuration).

## Operation
- States:
  - IDLE: cpuReady=1. cpuReq=1 latches the request, then goes to LOOKUP.
  - LOOKUP: compares the latched address with both tags; a line matches only if it is valid.
  - EVICT: write-back of the dirty victim line.
  - FILL: read of the missed address from RAM.
  - RESP: cpuDone=1 for this one cycle, then IDLE.
- LOOKUP, hit:
  - Read: return the line data.
  - Write: overwrite the line data and set dirty=1.
  - Both go to RESP with hit=1.
- LOOKUP, miss; victim selection:
  - Lowest-index invalid line if one exists.
  - Otherwise the line named by the LRU pointer.
- Miss, victim valid and dirty: EVICT.
  - ramReq=1, ramWrite=1, ramAddr = victim tag, ramDataOut = victim data.
  - Hold these until ramAck=1.
  - Then FILL for a read miss, or install for a write miss.
- Miss, victim clean or invalid: no RAM traffic for the victim.
- Read miss: FILL.
  - ramReq=1, ramWrite=0, ramAddr = cpuAddr.
  - On the ramAck edge, capture ramDataIn and install the line with valid=1, dirty=0.
  - Go to RESP with hit=0 and cpuDataOut = the filled data.
- Write miss: install cpuDataIn directly with valid=1, dirty=1. There is no fill. Go to RESP with hit=0.
- LRU: every access (hit or install) to line i sets the pointer to the other line (1-i).
- Duplicate tags never exist, because lookup always precedes install.
- ramAck is ignored in IDLE, LOOKUP and RESP.
- cpuReq while cpuReady=0 is ignored; the requester re-issues after cpuReady.

## Timing
- Reset values (resetN=0, applied immediately, asynchronously):
  - State = IDLE, all lines valid=0 and dirty=0, LRU pointer = 0.
  - Outputs: cpuReady=1; cpuDone=0, hit=0, cpuDataOut=0, ramReq=0, ramWrite=0, ramAddr=0, ramDataOut=0, hitCount=0, missCount=0.
- Hit latency: request accepted at edge N; LOOKUP during N..N+1; cpuDone high during cycle N+2..N+3; cpuReady high again at N+3.
- Miss latency: each RAM transaction adds the RAM wait plus 1 cycle. ramReq drops in the cycle after the ramAck edge.
- Back-to-back requests are possible: a new cpuReq is accepted on the first edge that cpuReady=1.
- ramAck on the same edge ramReq first rises completes the transaction; 1-cycle RAM is legal.
- Reset mid-EVICT/FILL: ramReq drops immediately, the transaction is abandoned, dirty data is lost, and no cpuDone is issued.
- Address 0xFF is a normal tag; there is no reserved address.

## Configuration
- CACHE_STATS_EN defined:
  - hitCount/missCount increment in LOOKUP on hit/miss.
  - 8-bit, saturating at 255.
  - Cleared only by reset.
- CACHE_STATS_EN undefined: the counters are not built; both ports are tied to 0.

## Test plan
- Reset, then read 0x64; RAM acks with 0x05 after 2 cycles → one fill at ramAddr=0x64, ramWrite=0; cpuDone with cpuDataOut=0x05, hit=0.
- Read 0x64 again → cpuDone exactly 2 cycles after accept, hit=1, 0x05, ramReq stays 0.
- Write 0x65←0xAA → installed in invalid line 1, no RAM traffic, hit=0; then read 0x65 → hit=1, 0xAA.
- Read 0x66 → victim line 0 (clean, LRU), fill only.
  - Then read 0x67 → victim line 1 (dirty): write-back ramAddr=0x65, ramDataOut=0xAA, then fill 0x67.
- Assert resetN low while ramReq=1 in FILL → ramReq=0 immediately, cpuReady=1, no cpuDone.
  - Then read 0x64 → miss.
- After the first four scenarios, in one continuous run without reset:
  - With CACHE_STATS_EN: hitCount=2, missCount=4.
  - Without CACHE_STATS_EN: both 0.
- Apply 300 hits with CACHE_STATS_EN → hitCount saturates at 255.

Source files
------------

// File: rtl/cache_miss_handler_if.sv
// cache_miss_handler_if: processor-side request port and RAM-side port of the cache controller.
// Ports:
//   cpuReq/cpuWrite/cpuAddr/cpuDataIn    request from the processor
//   cpuReady/cpuDone/cpuDataOut/hit      controller status and response to the processor
//   ramReq/ramWrite/ramAddr/ramDataOut   controller-initiated RAM transaction
//   ramAck/ramDataIn                     RAM completion and fill data
//   hitCount/missCount                   access statistics
// Modports: slave = the cache controller, master = the environment (processor plus RAM).
interface cache_miss_handler_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpuReq;
    logic              cpuWrite;
    logic [ADDR_W-1:0] cpuAddr;
    logic [DATA_W-1:0] cpuDataIn;
    logic              cpuReady;
    logic              cpuDone;
    logic [DATA_W-1:0] cpuDataOut;
    logic              hit;
    logic              ramReq;
    logic              ramWrite;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramDataOut;
    logic              ramAck;
    logic [DATA_W-1:0] ramDataIn;
    logic [7:0]        hitCount;
    logic [7:0]        missCount;

    modport slave (
        input  cpuReq, cpuWrite, cpuAddr, cpuDataIn, ramAck, ramDataIn,
        output cpuReady, cpuDone, cpuDataOut, hit,
        output ramReq, ramWrite, ramAddr, ramDataOut, hitCount, missCount
    );

    modport master (
        output cpuReq, cpuWrite, cpuAddr, cpuDataIn, ramAck, ramDataIn,
        input  cpuReady, cpuDone, cpuDataOut, hit,
        input  ramReq, ramWrite, ramAddr, ramDataOut, hitCount, missCount
    );
endinterface

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: write-back, write-allocate 2-line fully associative cache controller.
// Ports:
//   clock   rising-edge clock
//   resetN  asynchronous active-low reset
//   bus     cache_miss_handler_if.slave (processor request/response, RAM req/ack, statistics)
// Optional feature: define CACHE_STATS_EN to build saturating 8-bit hit/miss counters;
// otherwise hitCount and missCount are tied to 0.
module cache_miss_handler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic             clock,
    input logic             resetN,
    cache_miss_handler_if.slave bus
);
    // DECIDE is the second half of the lookup: LOOKUP registers the tag compare,
    // DECIDE acts on it, which places cpuDone two cycles after the accept edge.
    typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, EVICT, FILL, RESP} state_t;

    state_t                   state;
    logic                     req_write;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_data;
    logic [1:0][ADDR_W-1:0]   tag;
    logic [1:0][DATA_W-1:0]   data;
    logic [1:0]               valid;
    logic [1:0]               dirty;
    logic                     lru;
    logic                     is_hit;
    logic                     idx;
    logic [1:0]               match;
    logic                     victim;

    assign match[0] = valid[0] && tag[0] == req_addr;
    assign match[1] = valid[1] && tag[1] == req_addr;
    assign victim   = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            req_write      <= 1'b0;
            req_addr       <= '0;
            req_data       <= '0;
            tag            <= '0;
            data           <= '0;
            valid          <= '0;
            dirty          <= '0;
            lru            <= 1'b0;
            is_hit         <= 1'b0;
            idx            <= 1'b0;
            bus.cpuReady   <= 1'b1;
            bus.cpuDone    <= 1'b0;
            bus.hit        <= 1'b0;
            bus.cpuDataOut <= '0;
            bus.ramReq     <= 1'b0;
            bus.ramWrite   <= 1'b0;
            bus.ramAddr    <= '0;
            bus.ramDataOut <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpuReq) begin
                    req_write    <= bus.cpuWrite;
                    req_addr     <= bus.cpuAddr;
                    req_data     <= bus.cpuDataIn;
                    bus.cpuReady <= 1'b0;
                    state        <= LOOKUP;
                end
                LOOKUP: begin
                    is_hit <= |match;
                    idx    <= |match ? match[1] : victim;
                    state  <= DECIDE;
                end
                DECIDE: if (is_hit) begin
                    data[idx]      <= req_write ? req_data : data[idx];
                    dirty[idx]     <= dirty[idx] | req_write;
                    lru            <= ~idx;
                    bus.hit        <= 1'b1;
                    bus.cpuDataOut <= req_write ? req_data : data[idx];
                    bus.cpuDone    <= 1'b1;
                    state          <= RESP;
                end else if (valid[idx] && dirty[idx]) begin
                    state <= EVICT;
                end else if (req_write) begin
                    tag[idx]       <= req_addr;
                    data[idx]      <= req_data;
                    valid[idx]     <= 1'b1;
                    dirty[idx]     <= 1'b1;
                    lru            <= ~idx;
                    bus.hit        <= 1'b0;
                    bus.cpuDataOut <= req_data;
                    bus.cpuDone    <= 1'b1;
                    state          <= RESP;
                end else begin
                    state <= FILL;
                end
                // After the write-back the victim is clean, so DECIDE re-runs and
                // either installs the write or starts the fill.
                EVICT: if (!bus.ramReq) begin
                    bus.ramReq     <= 1'b1;
                    bus.ramWrite   <= 1'b1;
                    bus.ramAddr    <= tag[idx];
                    bus.ramDataOut <= data[idx];
                end else if (bus.ramAck) begin
                    bus.ramReq <= 1'b0;
                    dirty[idx] <= 1'b0;
                    state      <= DECIDE;
                end
                FILL: if (!bus.ramReq) begin
                    bus.ramReq   <= 1'b1;
                    bus.ramWrite <= 1'b0;
                    bus.ramAddr  <= req_addr;
                end else if (bus.ramAck) begin
                    bus.ramReq     <= 1'b0;
                    tag[idx]       <= req_addr;
                    data[idx]      <= bus.ramDataIn;
                    valid[idx]     <= 1'b1;
                    dirty[idx]     <= 1'b0;
                    lru            <= ~idx;
                    bus.hit        <= 1'b0;
                    bus.cpuDataOut <= bus.ramDataIn;
                    bus.cpuDone    <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    bus.cpuDone  <= 1'b0;
                    bus.cpuReady <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (|match && hit_cnt != 8'hFF)
                hit_cnt <= hit_cnt + 8'd1;
            if (!(|match) && miss_cnt != 8'hFF)
                miss_cnt <= miss_cnt + 8'd1;
        end
    end

    assign bus.hitCount  = hit_cnt;
    assign bus.missCount = miss_cnt;
`else
    assign bus.hitCount  = '0;
    assign bus.missCount = '0;
`endif
endmodule

// File: tb/tb_cache_miss_handler.sv
// tb_cache_miss_handler: scoreboard bench for cache_miss_handler with a RAM responder.
module tb_cache_miss_handler;
    logic clock  = 1'b0;
    logic resetN = 1'b0;

    always #5 clock = ~clock;

    cache_miss_handler_if bus();

    cache_miss_handler dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       hit;
        logic       chk;
    } rsp_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } ram_t;

    rsp_t rsp_q[$];
    ram_t ram_q[$];
    int   checks   = 0;
    int   errors   = 0;
    logic ram_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every cpuDone pulse consumes one expected response.
    initial begin
        forever begin
            @(negedge clock);
            if (resetN && bus.cpuDone) begin
                if (rsp_q.size() == 0) check("cpuDone_unexpected", bus.cpuDone, 0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("hit", bus.hit, r.hit);
                    if (r.chk) check("cpuDataOut", bus.cpuDataOut, r.data);
                end
            end
        end
    end

    // RAM responder and monitor: acks two cycles after ramReq rises, returns fill data.
    initial begin
        ram_t t;
        bus.ramAck    = 1'b0;
        bus.ramDataIn = '0;
        forever begin
            @(negedge clock);
            if (resetN && bus.ramReq) begin
                t = '{1'b0, 8'h00, 8'h00};
                if (ram_q.size() == 0) check("ramReq_unexpected", bus.ramReq, 0);
                else begin
                    t = ram_q.pop_front();
                    check("ramWrite", bus.ramWrite, t.wr);
                    check("ramAddr", bus.ramAddr, t.addr);
                    if (t.wr) check("ramDataOut", bus.ramDataOut, t.data);
                end
                if (ram_hold) begin
                    for (int i = 0; i < 100 && bus.ramReq; i++) @(negedge clock);
                end else begin
                    @(negedge clock);
                    bus.ramAck    = 1'b1;
                    bus.ramDataIn = t.data;
                    @(negedge clock);
                    bus.ramAck = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] din);
        int w = 0;
        while (!bus.cpuReady && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (w == 100) check("cpuReady_timeout", bus.cpuReady, 1);
        bus.cpuReq    = 1'b1;
        bus.cpuWrite  = wr;
        bus.cpuAddr   = addr;
        bus.cpuDataIn = din;
        @(posedge clock);
        #1 bus.cpuReq = 1'b0;
    endtask

    task automatic req(input logic wr, input logic [7:0] addr, input logic [7:0] din,
                       input logic [7:0] exp_data, input logic exp_hit, input bit chk_lat);
        int lat = 0;
        rsp_q.push_back('{exp_data, exp_hit, !wr});
        issue(wr, addr, din);
        while (!bus.cpuDone && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (chk_lat) check("hit_latency", lat, 2);
        else if (lat == 100) check("cpuDone_timeout", bus.cpuDone, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        bus.cpuReq    = 1'b0;
        bus.cpuWrite  = 1'b0;
        bus.cpuAddr   = '0;
        bus.cpuDataIn = '0;
        repeat (3) @(negedge clock);
        check("rst_cpuReady", bus.cpuReady, 1);
        check("rst_cpuDone", bus.cpuDone, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_cpuDataOut", bus.cpuDataOut, 0);
        check("rst_ramReq", bus.ramReq, 0);
        check("rst_ramWrite", bus.ramWrite, 0);
        check("rst_ramAddr", bus.ramAddr, 0);
        check("rst_ramDataOut", bus.ramDataOut, 0);
        check("rst_hitCount", bus.hitCount, 0);
        check("rst_missCount", bus.missCount, 0);
        resetN = 1'b1;
        @(negedge clock);

        ram_q.push_back('{1'b0, 8'h64, 8'h05});
        req(1'b0, 8'h64, 8'h00, 8'h05, 1'b0, 1'b0);
        req(1'b0, 8'h64, 8'h00, 8'h05, 1'b1, 1'b1);
        req(1'b1, 8'h65, 8'hAA, 8'hAA, 1'b0, 1'b0);
        req(1'b0, 8'h65, 8'h00, 8'hAA, 1'b1, 1'b1);
        ram_q.push_back('{1'b0, 8'h66, 8'h11});
        req(1'b0, 8'h66, 8'h00, 8'h11, 1'b0, 1'b0);
        ram_q.push_back('{1'b1, 8'h65, 8'hAA});
        ram_q.push_back('{1'b0, 8'h67, 8'h22});
        req(1'b0, 8'h67, 8'h00, 8'h22, 1'b0, 1'b0);
`ifdef CACHE_STATS_EN
        check("hitCount_run", bus.hitCount, 2);
        check("missCount_run", bus.missCount, 4);
`else
        check("hitCount_run", bus.hitCount, 0);
        check("missCount_run", bus.missCount, 0);
`endif

        ram_hold = 1'b1;
        ram_q.push_back('{1'b0, 8'h68, 8'h00});
        issue(1'b0, 8'h68, 8'h00);
        w = 0;
        while (!bus.ramReq && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("ramReq_in_fill", bus.ramReq, 1);
        #2 resetN = 1'b0;
        #1;
        check("abort_ramReq", bus.ramReq, 0);
        check("abort_cpuReady", bus.cpuReady, 1);
        check("abort_cpuDone", bus.cpuDone, 0);
        check("abort_missCount", bus.missCount, 0);
        repeat (2) @(negedge clock);
        resetN   = 1'b1;
        ram_hold = 1'b0;
        @(negedge clock);

        ram_q.push_back('{1'b0, 8'h64, 8'h33});
        req(1'b0, 8'h64, 8'h00, 8'h33, 1'b0, 1'b0);
        req(1'b1, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1'b0);
        req(1'b0, 8'hFF, 8'h00, 8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) req(1'b0, 8'h64, 8'h00, 8'h33, 1'b1, 1'b0);
`ifdef CACHE_STATS_EN
        check("hitCount_sat", bus.hitCount, 255);
        check("missCount_final", bus.missCount, 2);
`else
        check("hitCount_sat", bus.hitCount, 0);
        check("missCount_final", bus.missCount, 0);
`endif

        repeat (4) @(negedge clock);
        check("rsp_q_drained", rsp_q.size(), 0);
        check("ram_q_drained", ram_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
